inst_memory_pipe: RTL
=====================

# inst_memory_pipe

Parametrised instruction memory for the CPU fetch stage, successor to the fixed single-cycle instruction store. It adds a valid/ready fetch request port with configurable read latency, a program-load write port, a sequential post-reset clear sequence, and per-response plus sticky out-of-range exceptions. It sits between the PC/fetch logic and the decode stage, and is loaded by the test or boot loader through the load port.

## Interface
- `INSTR_ADDR_WIDTH`, 16, width of fetch and load addresses.
- `INSTR_DATA_BIT_WIDTH`, 16, instruction word width.
- `INSTR_MEM_SIZE`, 64, number of words; legal addresses are 0..INSTR_MEM_SIZE-1.
- `READ_LATENCY`, 1, cycles from accepted request to response; legal range 1..4.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  fetch request present.
- `req_addr`  in  INSTR_ADDR_WIDTH  fetch word address.
- `req_ready`  out  1  memory can accept a fetch this cycle.
- `rsp_valid`  out  1  response word valid; single-cycle pulse per accepted request.
- `rsp_data`  out  INSTR_DATA_BIT_WIDTH  fetched instruction.
- `rsp_exc`  out  1  response address was out of range; qualified by `rsp_valid`.
- `ld_en`  in  1  program-load write strobe.
- `ld_addr`  in  INSTR_ADDR_WIDTH  load word address.
- `ld_data`  in  INSTR_DATA_BIT_WIDTH  load word.
- `ld_err`  out  1  one-cycle pulse: load address out of range, write dropped.
- `exc_flag`  out  1  sticky OR of all `rsp_exc` and `ld_err` events.
- `exc_clr`  in  1  clears `exc_flag`.

## Operation
- FSM states: INIT and RUN.
- INIT is entered on reset. A counter walks addresses 0..INSTR_MEM_SIZE-1 and writes 0, one word per cycle. The FSM moves to RUN after writing the last word.
- In INIT:
  - `req_ready` = 0.
  - `ld_en` is ignored.
- `req_ready` = 1 in RUN when `ld_en` = 0.
  - `ld_en` = 1 has priority and forces `req_ready` = 0 that cycle.
  - As a result, a read and a write never occur in the same cycle.
- A fetch is accepted when `req_valid` && `req_ready`.
  - In range: the response carries `mem[req_addr]`, `rsp_exc` = 0.
  - Out of range (`req_addr` >= INSTR_MEM_SIZE): the response carries `rsp_data` = 0, `rsp_exc` = 1.
- Responses have no backpressure. One accepted request per cycle is allowed, and responses return in request order.
- Load in RUN:
  - In range: write `ld_data` to `mem[ld_addr]`.
  - Out of range: no write, and `ld_err` pulses on the next cycle.
- `exc_flag`:
  - Set on any cycle where `rsp_valid` && `rsp_exc`, or where `ld_err` is asserted.
  - `exc_clr` clears it. If a set event and `exc_clr` occur in the same cycle, set wins.
- Address comparison uses the full INSTR_ADDR_WIDTH. There is no wrap-around and no truncation to the memory index width.

## Timing
- Reset values:
  - `req_ready`, `rsp_valid`, `rsp_exc`, `ld_err`, `exc_flag` = 0.
  - `rsp_data` = 0.
  - FSM = INIT, clear counter = 0.
  - All in-flight pipeline stages are invalidated.
- Reset deassert, then INIT lasts exactly INSTR_MEM_SIZE cycles. `req_ready` first rises on cycle INSTR_MEM_SIZE after the first clock edge with `rst` high.
- Reset asserted mid-INIT or mid-RUN: all in-flight responses are discarded and INIT restarts from address 0.
- Request accepted at edge T: `rsp_valid` is high for the cycle following edge T+READ_LATENCY-1.
  - READ_LATENCY = 1 gives a response one cycle after acceptance.
  - Data is registered in every stage.
- A load at edge T is visible to a request accepted at edge T+1 or later.
- `rsp_data` holds its last value while `rsp_valid` = 0.
- `ld_err` is a single-cycle pulse, one cycle after the offending `ld_en`.

## Test plan
- Reset then idle, INSTR_MEM_SIZE = 64:
  - `req_ready` stays 0 for 64 cycles, then goes to 1.
  - A fetch of addresses 0, 31 and 63 returns 0 with `rsp_exc` = 0.
- Load then fetch back-to-back:
  - Load 0xA5A5 at address 5, then fetch address 5 on the next cycle.
  - Expect `rsp_data` = 0xA5A5 after READ_LATENCY cycles.
  - `req_ready` = 0 in the load cycle.
- Streaming with READ_LATENCY = 3:
  - Fetch addresses 1, 2, 3 on consecutive cycles (preloaded with 0x0011, 0x0022, 0x0033).
  - Expect three consecutive `rsp_valid` pulses starting 3 cycles after the first request, in order.
- Out-of-range fetch at address 64:
  - Expect `rsp_valid` = 1, `rsp_exc` = 1, `rsp_data` = 0, and `exc_flag` = 1 afterwards.
  - Pulse `exc_clr`: `exc_flag` returns to 0.
- Out-of-range load at 0x0100:
  - Expect a one-cycle `ld_err` pulse and `exc_flag` set.
  - A subsequent fetch of addresses 0..63 shows no memory change.
- Reset mid-stream:
  - Assert `rst` while 2 responses are in flight.
  - No `rsp_valid` appears after reset.
  - INIT repeats for 64 cycles and previously loaded words read back as 0.

Source files
------------

// File: rtl/inst_memory_pipe.sv
`default_nettype none
// ============================================================================
// Module   : inst_memory_pipe
// Brief    : Instruction memory with valid/ready fetch, program-load port,
//            post-reset clear sequence and out-of-range exceptions.
// Revision : 1.0 - initial release
// ============================================================================
module inst_memory_pipe #(
  parameter int INSTR_ADDR_WIDTH     = 16,
  parameter int INSTR_DATA_BIT_WIDTH = 16,
  parameter int INSTR_MEM_SIZE       = 64,
  parameter int READ_LATENCY         = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  input  logic [INSTR_ADDR_WIDTH-1:0]     req_addr,
  output logic                            req_ready,
  output logic                            rsp_valid,
  output logic [INSTR_DATA_BIT_WIDTH-1:0] rsp_data,
  output logic                            rsp_exc,
  input  logic                            ld_en,
  input  logic [INSTR_ADDR_WIDTH-1:0]     ld_addr,
  input  logic [INSTR_DATA_BIT_WIDTH-1:0] ld_data,
  output logic                            ld_err,
  output logic                            exc_flag,
  input  logic                            exc_clr
);

  localparam int c_idx_w = $clog2(INSTR_MEM_SIZE);
  localparam logic [INSTR_ADDR_WIDTH:0] c_size = (INSTR_ADDR_WIDTH+1)'(INSTR_MEM_SIZE);
  localparam logic [c_idx_w-1:0] c_last = c_idx_w'(INSTR_MEM_SIZE - 1);

  typedef enum logic [0:0] {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t                          r_state, w_state_nxt;
  logic [c_idx_w-1:0]              r_clr_cnt, w_clr_cnt_nxt;
  logic [INSTR_DATA_BIT_WIDTH-1:0] r_mem [INSTR_MEM_SIZE];

  logic                            r_pv [READ_LATENCY];
  logic [INSTR_DATA_BIT_WIDTH-1:0] r_pd [READ_LATENCY];
  logic                            r_pe [READ_LATENCY];
  logic                            r_ld_err;
  logic                            r_exc_flag;

  logic                            w_req_in_range;
  logic                            w_ld_in_range;
  logic                            w_accept;
  logic                            w_we;
  logic [c_idx_w-1:0]              w_waddr;
  logic [INSTR_DATA_BIT_WIDTH-1:0] w_wdata;
  logic                            w_exc_set;

  // Full-width compares: addresses beyond the array never alias onto it.
  assign w_req_in_range = {1'b0, req_addr} < c_size;
  assign w_ld_in_range  = {1'b0, ld_addr} < c_size;

  assign req_ready = (r_state == S_RUN) && !ld_en;
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_INIT;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_we          = 1'b0;
    w_waddr       = ld_addr[c_idx_w-1:0];
    w_wdata       = ld_data;
    case (r_state)
      S_INIT: begin
        w_we          = 1'b1;
        w_waddr       = r_clr_cnt;
        w_wdata       = '0;
        w_clr_cnt_nxt = r_clr_cnt + c_idx_w'(1);
        if (r_clr_cnt == c_last) begin
          w_state_nxt   = S_RUN;
          w_clr_cnt_nxt = '0;
        end
      end
      S_RUN: begin
        w_we = ld_en && w_ld_in_range;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Data and exception bits only advance with a valid token, so the output
  // stage holds the last response while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        r_pv[k] <= 1'b0;
        r_pd[k] <= '0;
        r_pe[k] <= 1'b0;
      end
    end else begin
      r_pv[0] <= w_accept;
      if (w_accept) begin
        r_pd[0] <= w_req_in_range ? r_mem[req_addr[c_idx_w-1:0]] : '0;
        r_pe[0] <= !w_req_in_range;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_pv[k] <= r_pv[k-1];
        if (r_pv[k-1]) begin
          r_pd[k] <= r_pd[k-1];
          r_pe[k] <= r_pe[k-1];
        end
      end
    end
  end

  assign rsp_valid = r_pv[READ_LATENCY-1];
  assign rsp_data  = r_pd[READ_LATENCY-1];
  assign rsp_exc   = r_pe[READ_LATENCY-1];

  assign w_exc_set = (rsp_valid && rsp_exc) || r_ld_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld_err   <= 1'b0;
      r_exc_flag <= 1'b0;
    end else begin
      r_ld_err <= (r_state == S_RUN) && ld_en && !w_ld_in_range;
      if (w_exc_set) begin
        r_exc_flag <= 1'b1;
      end else if (exc_clr) begin
        r_exc_flag <= 1'b0;
      end
    end
  end

  assign ld_err   = r_ld_err;
  assign exc_flag = r_exc_flag;

endmodule
`default_nettype wire
